// File: rtl/tsn_gcl_pkg.sv
// Shared types and constants for the time-aware gate scheduler.
package tsn_gcl_pkg;

    localparam int GCL_DEPTH  = 16;
    localparam int INTERVAL_W = 24;
    localparam int QUEUE_NUM  = 4;
    localparam int ADDR_W     = $clog2(GCL_DEPTH);
    localparam int LEN_W      = ADDR_W + 1;

    localparam logic [QUEUE_NUM-1:0] GATES_ALL_OPEN = 4'hF;

    typedef struct packed {
        logic [QUEUE_NUM-1:0]  gate_mask;
        logic [INTERVAL_W-1:0] interval;
    } gcl_entry_t;

    typedef enum logic {
        S_IDLE,
        S_RUN
    } sched_state_e;

    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
        return (l > LEN_W'(GCL_DEPTH)) ? LEN_W'(GCL_DEPTH) : l;
    endfunction

    // An interval of 0 behaves as 1, so both load a remaining count of 0.
    function automatic logic [INTERVAL_W-1:0] first_count(
        input logic [INTERVAL_W-1:0] iv
    );
        return (iv == '0) ? '0 : iv - INTERVAL_W'(1);
    endfunction

endpackage

// File: rtl/gcl_bank_regs.sv
// Double-buffered gate control list: shadow write port, active/next read ports.
module gcl_bank_regs
    import tsn_gcl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en_i,
    input  logic [ADDR_W-1:0]     wr_addr_i,
    input  gcl_entry_t            wr_entry_i,
    input  logic                  len_wr_i,
    input  logic [LEN_W-1:0]      len_i,
    input  logic                  swap_i,
    input  logic                  ld_shadow_i,
    input  logic [ADDR_W-1:0]     ld_addr_i,
    output logic [INTERVAL_W-1:0] ld_iv_o,
    output logic [LEN_W-1:0]      ld_len_o,
    input  logic [ADDR_W-1:0]     act_addr_i,
    output logic [QUEUE_NUM-1:0]  act_mask_o,
    output logic [LEN_W-1:0]      act_len_o
);

    gcl_entry_t       bank_q [2][GCL_DEPTH];
    logic [LEN_W-1:0] len_q  [2];
    logic             sel_q;
    logic             ld_sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                len_q[b] <= '0;
                for (int e = 0; e < GCL_DEPTH; e++) begin
                    bank_q[b][e] <= '0;
                end
            end
            sel_q <= 1'b0;
        end else begin
            if (wr_en_i) begin
                bank_q[~sel_q][wr_addr_i] <= wr_entry_i;
            end
            if (len_wr_i) begin
                len_q[~sel_q] <= clamp_len(len_i);
            end
            if (swap_i) begin
                sel_q <= ~sel_q;
            end
        end
    end

    // The load port can look through to the shadow bank that a swap is about to expose.
    assign ld_sel     = sel_q ^ ld_shadow_i;
    assign ld_iv_o    = bank_q[ld_sel][ld_addr_i].interval;
    assign ld_len_o   = len_q[ld_sel];
    assign act_mask_o = bank_q[sel_q][act_addr_i].gate_mask;
    assign act_len_o  = len_q[sel_q];

endmodule

// File: rtl/tsn_gcl_sched.sv
// Time-aware gate scheduler: walks the active GCL and drives registered gate state.
module tsn_gcl_sched
    import tsn_gcl_pkg::*;
#(
    parameter int GCL_DEPTH  = tsn_gcl_pkg::GCL_DEPTH,
    parameter int INTERVAL_W = tsn_gcl_pkg::INTERVAL_W,
    parameter int QUEUE_NUM  = tsn_gcl_pkg::QUEUE_NUM
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         sched_en,
    input  logic                         gcl_wr,
    input  logic [$clog2(GCL_DEPTH)-1:0] gcl_addr,
    input  logic [31:0]                  gcl_data,
    input  logic                         gcl_len_wr,
    input  logic [$clog2(GCL_DEPTH):0]   gcl_len,
    input  logic                         gcl_commit,
    output logic [QUEUE_NUM-1:0]         gate_state,
    output logic                         time_slot_flag,
    output logic                         cycle_start,
    output logic [$clog2(GCL_DEPTH)-1:0] cur_entry,
    output logic                         commit_pending,
    output logic [31:0]                  cycle_cnt
);

    sched_state_e          state_q, state_d;
    logic [ADDR_W-1:0]     idx_q, idx_d, ld_addr;
    logic [INTERVAL_W-1:0] rem_q, rem_d, ld_iv;
    logic                  first_q, first_d;
    logic                  wrap_q, wrap_d;
    logic                  pend_q, pend_d;
    logic                  swap, ld_shadow, last;
    logic [LEN_W-1:0]      ld_len, act_len;
    logic [QUEUE_NUM-1:0]  act_mask;

    logic [QUEUE_NUM-1:0]  gate_q;
    logic                  tsf_q, cs_q;
    logic [ADDR_W-1:0]     cur_q;
    logic [31:0]           cyc_q;
    logic                  unused_data;

    assign unused_data = ^gcl_data[31:QUEUE_NUM+INTERVAL_W];

    gcl_bank_regs u_banks (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en_i    (gcl_wr),
        .wr_addr_i  (gcl_addr),
        .wr_entry_i (gcl_entry_t'(gcl_data[QUEUE_NUM+INTERVAL_W-1:0])),
        .len_wr_i   (gcl_len_wr),
        .len_i      (gcl_len),
        .swap_i     (swap),
        .ld_shadow_i(ld_shadow),
        .ld_addr_i  (ld_addr),
        .ld_iv_o    (ld_iv),
        .ld_len_o   (ld_len),
        .act_addr_i (idx_q),
        .act_mask_o (act_mask),
        .act_len_o  (act_len)
    );

    assign last = ({1'b0, idx_q} + LEN_W'(1)) == act_len;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        rem_d     = rem_q;
        first_d   = 1'b0;
        wrap_d    = 1'b0;
        pend_d    = pend_q;
        swap      = 1'b0;
        ld_shadow = 1'b0;
        ld_addr   = '0;
        unique case (state_q)
            S_IDLE: begin
                if (gcl_commit || pend_q) begin
                    swap      = 1'b1;
                    ld_shadow = 1'b1;
                    pend_d    = 1'b0;
                end
                if (sched_en && ld_len != '0) begin
                    state_d = S_RUN;
                    idx_d   = '0;
                    rem_d   = first_count(ld_iv);
                    first_d = 1'b1;
                end
            end
            S_RUN: begin
                if (gcl_commit) begin
                    pend_d = 1'b1;
                end
                if (!sched_en) begin
                    state_d = S_IDLE;
                end else if (rem_q != '0) begin
                    rem_d = rem_q - INTERVAL_W'(1);
                end else begin
                    first_d = 1'b1;
                    if (last) begin
                        wrap_d = 1'b1;
                        idx_d  = '0;
                        // The swap and entry-0 fetch share one edge, so no stale mask shows.
                        if (gcl_commit || pend_q) begin
                            swap      = 1'b1;
                            ld_shadow = 1'b1;
                            pend_d    = 1'b0;
                        end
                        if (ld_len == '0) begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        idx_d   = idx_q + ADDR_W'(1);
                        ld_addr = idx_q + ADDR_W'(1);
                    end
                    rem_d = first_count(ld_iv);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            rem_q   <= '0;
            first_q <= 1'b0;
            wrap_q  <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rem_q   <= rem_d;
            first_q <= first_d;
            wrap_q  <= wrap_d;
            pend_q  <= pend_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gate_q <= GATES_ALL_OPEN;
            tsf_q  <= 1'b0;
            cs_q   <= 1'b0;
            cur_q  <= '0;
            cyc_q  <= '0;
        end else begin
            cyc_q <= cyc_q + 32'(wrap_q);
            if (state_q == S_RUN) begin
                gate_q <= act_mask;
                tsf_q  <= first_q;
                cs_q   <= first_q && (idx_q == '0);
                cur_q  <= idx_q;
            end else begin
                gate_q <= GATES_ALL_OPEN;
                tsf_q  <= 1'b0;
                cs_q   <= 1'b0;
                cur_q  <= '0;
            end
        end
    end

    assign gate_state     = gate_q;
    assign time_slot_flag = tsf_q;
    assign cycle_start    = cs_q;
    assign cur_entry      = cur_q;
    assign commit_pending = pend_q;
    assign cycle_cnt      = cyc_q;

endmodule

// File: tb/tb_tsn_gcl_sched.sv
// Scoreboard bench for tsn_gcl_sched: expected per-cycle outputs queued, popped at negedge.
`timescale 1ns/1ps
module tb_tsn_gcl_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        sched_en = 1'b0;
    logic        gcl_wr = 1'b0;
    logic [3:0]  gcl_addr = '0;
    logic [31:0] gcl_data = '0;
    logic        gcl_len_wr = 1'b0;
    logic [4:0]  gcl_len = '0;
    logic        gcl_commit = 1'b0;
    logic [3:0]  gate_state;
    logic        time_slot_flag;
    logic        cycle_start;
    logic [3:0]  cur_entry;
    logic        commit_pending;
    logic [31:0] cycle_cnt;

    typedef struct packed {
        logic [3:0]  gate;
        logic        tsf;
        logic        cs;
        logic [3:0]  cur;
        logic        pend;
        logic [31:0] cyc;
    } obs_t;

    obs_t exp_q[$];
    int   total = 0;
    int   bad = 0;

    tsn_gcl_sched dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .sched_en      (sched_en),
        .gcl_wr        (gcl_wr),
        .gcl_addr      (gcl_addr),
        .gcl_data      (gcl_data),
        .gcl_len_wr    (gcl_len_wr),
        .gcl_len       (gcl_len),
        .gcl_commit    (gcl_commit),
        .gate_state    (gate_state),
        .time_slot_flag(time_slot_flag),
        .cycle_start   (cycle_start),
        .cur_entry     (cur_entry),
        .commit_pending(commit_pending),
        .cycle_cnt     (cycle_cnt)
    );

    always #5 clk = ~clk;

    function automatic obs_t mk(input logic [3:0] g, input logic t, input logic c,
                                input logic [3:0] e, input logic p, input logic [31:0] n);
        obs_t o;
        o.gate = g;
        o.tsf  = t;
        o.cs   = c;
        o.cur  = e;
        o.pend = p;
        o.cyc  = n;
        return o;
    endfunction

    function automatic obs_t get_obs();
        return {gate_state, time_slot_flag, cycle_start, cur_entry, commit_pending, cycle_cnt};
    endfunction

    task automatic push_idle(input int n, input logic [31:0] cyc);
        repeat (n) exp_q.push_back(mk(4'hF, 1'b0, 1'b0, 4'h0, 1'b0, cyc));
    endtask

    task automatic push_entry(input logic [3:0] m, input int iv, input logic [3:0] idx,
                              input logic [31:0] cyc);
        int n;
        n = (iv == 0) ? 1 : iv;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(mk(m, i == 0, (i == 0) && (idx == 4'h0), idx, 1'b0, cyc));
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_entry(input logic [3:0] a, input logic [3:0] m, input logic [23:0] iv);
        gcl_addr = a;
        gcl_data = {4'hA, m, iv};
        gcl_wr   = 1'b1;
        step();
        gcl_wr   = 1'b0;
    endtask

    task automatic wr_len(input logic [4:0] l);
        gcl_len    = l;
        gcl_len_wr = 1'b1;
        step();
        gcl_len_wr = 1'b0;
    endtask

    task automatic commit_idle();
        gcl_commit = 1'b1;
        step();
        gcl_commit = 1'b0;
    endtask

    task automatic do_reset();
        sched_en   = 1'b0;
        gcl_commit = 1'b0;
        exp_q.delete();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic load_basic();
        wr_entry(4'd0, 4'h1, 24'd5);
        wr_entry(4'd1, 4'h2, 24'd3);
        wr_entry(4'd2, 4'hC, 24'd2);
        wr_len(5'd3);
        commit_idle();
    endtask

    task automatic test_reset();
        obs_t e, o;
        #2 rst_n = 1'b0;
        #1;
        o = get_obs();
        e = mk(4'hF, 1'b0, 1'b0, 4'h0, 1'b0, 32'd0);
        total++;
        if (o !== e) begin
            bad++;
            $display("FAIL reset_values got=%h exp=%h", o, e);
        end
        step();
        rst_n    = 1'b1;
        sched_en = 1'b1;
        push_idle(4, 32'd0);
        for (int k = 0; exp_q.size() > 0; k++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            o = get_obs();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL empty_len_idle k=%0d got=%h exp=%h", k, o, e);
            end
        end
    endtask

    task automatic test_basic_cycle();
        obs_t e, o;
        do_reset();
        load_basic();
        sched_en = 1'b1;
        push_idle(2, 32'd0);
        push_entry(4'h1, 5, 4'd0, 32'd0);
        push_entry(4'h2, 3, 4'd1, 32'd0);
        push_entry(4'hC, 2, 4'd2, 32'd0);
        push_entry(4'h1, 5, 4'd0, 32'd1);
        push_entry(4'h2, 3, 4'd1, 32'd1);
        push_entry(4'hC, 2, 4'd2, 32'd1);
        push_entry(4'h1, 2, 4'd0, 32'd2);
        for (int k = 0; exp_q.size() > 0; k++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            o = get_obs();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL basic k=%0d got=%h exp=%h", k, o, e);
            end
        end
    endtask

    task automatic test_zero_interval();
        obs_t e, o;
        do_reset();
        wr_entry(4'd0, 4'h3, 24'd0);
        wr_entry(4'd1, 4'h5, 24'd2);
        wr_entry(4'd2, 4'h9, 24'd3);
        wr_len(5'd2);
        commit_idle();
        sched_en = 1'b1;
        push_idle(2, 32'd0);
        push_entry(4'h3, 0, 4'd0, 32'd0);
        push_entry(4'h5, 2, 4'd1, 32'd0);
        push_entry(4'h3, 0, 4'd0, 32'd1);
        push_entry(4'h5, 2, 4'd1, 32'd1);
        push_entry(4'h3, 0, 4'd0, 32'd2);
        for (int k = 0; exp_q.size() > 0; k++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            o = get_obs();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL zero_iv k=%0d got=%h exp=%h", k, o, e);
            end
        end
    endtask

    task automatic test_len_clamp();
        obs_t e, o;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            wr_entry(4'(i), 4'(i) ^ 4'h5, 24'd1);
        end
        wr_len(5'd20);
        commit_idle();
        sched_en = 1'b1;
        push_idle(2, 32'd0);
        for (int i = 0; i < 16; i++) begin
            push_entry(4'(i) ^ 4'h5, 1, 4'(i), 32'd0);
        end
        push_entry(4'h5, 1, 4'd0, 32'd1);
        for (int k = 0; exp_q.size() > 0; k++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            o = get_obs();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL len_clamp k=%0d got=%h exp=%h", k, o, e);
            end
        end
    endtask

    // Commit pulse driven right after sample at_k; the wrap edge lands just after sample 10.
    task automatic test_commit_run(input int at_k);
        obs_t e, o;
        do_reset();
        load_basic();
        wr_entry(4'd0, 4'h8, 24'd4);
        wr_len(5'd1);
        sched_en = 1'b1;
        push_idle(2, 32'd0);
        push_entry(4'h1, 5, 4'd0, 32'd0);
        push_entry(4'h2, 3, 4'd1, 32'd0);
        push_entry(4'hC, 2, 4'd2, 32'd0);
        push_entry(4'h8, 4, 4'd0, 32'd1);
        push_entry(4'h8, 4, 4'd0, 32'd2);
        for (int k = 0; exp_q.size() > 0; k++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            e.pend = (k >= at_k + 1) && (k <= 10);
            o = get_obs();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL commit_at_%0d k=%0d got=%h exp=%h", at_k, k, o, e);
            end
            gcl_commit = (k == at_k);
        end
        gcl_commit = 1'b0;
    endtask

    task automatic test_disable();
        obs_t e, o;
        do_reset();
        load_basic();
        sched_en = 1'b1;
        push_idle(2, 32'd0);
        push_entry(4'h1, 5, 4'd0, 32'd0);
        push_entry(4'h2, 2, 4'd1, 32'd0);
        push_idle(3, 32'd0);
        push_entry(4'h1, 5, 4'd0, 32'd0);
        push_entry(4'h2, 3, 4'd1, 32'd0);
        for (int k = 0; exp_q.size() > 0; k++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            o = get_obs();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL disable k=%0d got=%h exp=%h", k, o, e);
            end
            if (k == 7) sched_en = 1'b0;
            if (k == 10) sched_en = 1'b1;
        end
    endtask

    task automatic test_reset_mid_run();
        obs_t e, o;
        do_reset();
        load_basic();
        sched_en = 1'b1;
        push_idle(2, 32'd0);
        push_entry(4'h1, 5, 4'd0, 32'd0);
        push_entry(4'h2, 3, 4'd1, 32'd0);
        push_entry(4'hC, 2, 4'd2, 32'd0);
        exp_q.push_back(mk(4'h1, 1'b1, 1'b1, 4'd0, 1'b0, 32'd1));
        exp_q.push_back(mk(4'h1, 1'b0, 1'b0, 4'd0, 1'b1, 32'd1));
        for (int k = 0; exp_q.size() > 0; k++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            o = get_obs();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL pre_reset k=%0d got=%h exp=%h", k, o, e);
            end
            gcl_commit = (k == 12);
        end
        gcl_commit = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        o = get_obs();
        e = mk(4'hF, 1'b0, 1'b0, 4'h0, 1'b0, 32'd0);
        total++;
        if (o !== e) begin
            bad++;
            $display("FAIL async_reset got=%h exp=%h", o, e);
        end
        step();
        rst_n = 1'b1;
        push_idle(4, 32'd0);
        for (int k = 0; exp_q.size() > 0; k++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            o = get_obs();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL post_reset_idle k=%0d got=%h exp=%h", k, o, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_cycle();
        test_zero_interval();
        test_len_clamp();
        test_commit_run(7);
        test_commit_run(10);
        test_disable();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
